// File: rtl/nq_bus_unit.sv
// Multi-port memory-bus unit: arbitrates NPORTS requesters onto one external bus
// with byte enables, write support, wait states and an optional wait-state timeout.
module nq_bus_unit #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int NPORTS  = 2,
  parameter int ARB_RR  = 0,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NPORTS-1:0]          req_i,
  input  logic [NPORTS-1:0]          we_i,
  input  logic [NPORTS*ADDR_W-1:0]   addr_i,
  input  logic [NPORTS*DATA_W-1:0]   wdata_i,
  input  logic [NPORTS*DATA_W/8-1:0] be_i,
  output logic [NPORTS-1:0]          gnt_o,
  output logic [NPORTS-1:0]          done_o,
  output logic [NPORTS-1:0]          err_o,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [ADDR_W-1:0]          addr_o,
  output logic                       re_o,
  output logic                       we_o,
  output logic [DATA_W/8-1:0]        be_o,
  inout  wire  [DATA_W-1:0]          data_io,
  input  logic                       needWait_i
);

  localparam int BW = DATA_W / 8;
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state_q, state_d;
  logic [NPORTS-1:0]   gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                re_q, re_d, we_q, we_d;
  logic [BW-1:0]       be_q, be_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [NPORTS-1:0]   elig;
  int                  win;
  int                  arb_idx;
  logic                win_vld;

  // A port is masked in its own done cycle so it may drop req one cycle late.
  assign elig = req_i & ~done_q;

  // Scan from the highest offset down so the lowest offset from the start point wins.
  always_comb begin
    win     = 0;
    win_vld = 1'b0;
    arb_idx = 0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      arb_idx = (ARB_RR != 0) ? int'(ptr_q) + i : i;
      if (arb_idx >= NPORTS) arb_idx = arb_idx - NPORTS;
      if (elig[arb_idx]) begin
        win     = arb_idx;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    re_d    = re_q;
    we_d    = we_q;
    be_d    = be_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          addr_d     = addr_i[win*ADDR_W +: ADDR_W];
          wdata_d    = wdata_i[win*DATA_W +: DATA_W];
          be_d       = be_i[win*BW +: BW];
          we_d       = we_i[win];
          re_d       = ~we_i[win];
          cnt_d      = '0;
          state_d    = ACCESS;
          if (ARB_RR != 0) ptr_d = (win == NPORTS - 1) ? '0 : PW'(win + 1);
        end
      end
      ACCESS: begin
        if (!needWait_i) begin
          if (re_q) rdata_d = data_io;
          done_d  = gnt_q;
          gnt_d   = '0;
          re_d    = 1'b0;
          we_d    = 1'b0;
          be_d    = '0;
          state_d = IDLE;
        end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
          done_d  = gnt_q;
          err_d   = gnt_q;
          gnt_d   = '0;
          re_d    = 1'b0;
          we_d    = 1'b0;
          be_d    = '0;
          state_d = IDLE;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      re_q    <= re_d;
      we_q    <= we_d;
      be_q    <= be_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;
  assign addr_o  = addr_q;
  assign re_o    = re_q;
  assign we_o    = we_q;
  assign be_o    = be_q;
  assign data_io = we_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_nq_bus_unit.sv
// Directed bench: fixed-priority 2-port unit with TIMEOUT=4 and a 3-port round-robin unit.
module tb_nq_bus_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Unit A: 2 ports, fixed priority, TIMEOUT=4
  logic [1:0]  a_req, a_we, a_gnt, a_done, a_err, a_be_o;
  logic [31:0] a_addr, a_wdata;
  logic [3:0]  a_be;
  logic [15:0] a_rdata, a_addr_o, a_slv;
  logic        a_re, a_we_o, a_nw;
  wire  [15:0] a_data;
  assign a_data = a_re ? a_slv : 16'hzzzz;

  nq_bus_unit #(.ADDR_W(16), .DATA_W(16), .NPORTS(2), .ARB_RR(0), .TIMEOUT(4)) u_a (
    .clk(clk), .rst(rst), .req_i(a_req), .we_i(a_we), .addr_i(a_addr), .wdata_i(a_wdata),
    .be_i(a_be), .gnt_o(a_gnt), .done_o(a_done), .err_o(a_err), .rdata_o(a_rdata),
    .addr_o(a_addr_o), .re_o(a_re), .we_o(a_we_o), .be_o(a_be_o), .data_io(a_data),
    .needWait_i(a_nw));

  // Unit B: 3 ports, round-robin, no timeout
  logic [2:0]  b_req, b_we, b_gnt, b_done, b_err;
  logic [47:0] b_addr, b_wdata;
  logic [5:0]  b_be;
  logic [1:0]  b_be_o;
  logic [15:0] b_rdata, b_addr_o, b_slv;
  logic        b_re, b_we_o, b_nw;
  wire  [15:0] b_data;
  assign b_data = b_re ? b_slv : 16'hzzzz;

  nq_bus_unit #(.ADDR_W(16), .DATA_W(16), .NPORTS(3), .ARB_RR(1), .TIMEOUT(0)) u_b (
    .clk(clk), .rst(rst), .req_i(b_req), .we_i(b_we), .addr_i(b_addr), .wdata_i(b_wdata),
    .be_i(b_be), .gnt_o(b_gnt), .done_o(b_done), .err_o(b_err), .rdata_o(b_rdata),
    .addr_o(b_addr_o), .re_o(b_re), .we_o(b_we_o), .be_o(b_be_o), .data_io(b_data),
    .needWait_i(b_nw));

  int exp_g [7] = '{0, 1, 0, 1, 2, 0, 1};

  initial begin
    rst = 1'b1;
    a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0; a_be = '0; a_slv = '0; a_nw = 1'b0;
    b_req = '0; b_we = '0; b_wdata = '0; b_be = 6'b111111; b_slv = '0; b_nw = 1'b0;
    b_addr = {16'h1002, 16'h1001, 16'h1000};
    step(); step();
    chk("rst_gnt", a_gnt, 0);
    chk("rst_done", a_done, 0);
    chk("rst_re", a_re, 0);
    chk("rst_we", a_we_o, 0);
    chk("rst_be", a_be_o, 0);
    chk("rst_addr", a_addr_o, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_b_gnt", b_gnt, 0);
    rst = 1'b0;
    step();

    // Single zero-wait read on port 0
    a_req = 2'b01; a_addr = {16'h0200, 16'h0100}; a_be = 4'b0111; a_slv = 16'hBEEF;
    step();
    chk("t1_re", a_re, 1);
    chk("t1_gnt", a_gnt, 2'b01);
    chk("t1_addr", a_addr_o, 16'h0100);
    chk("t1_be", a_be_o, 2'b11);
    chk("t1_done_early", a_done, 0);
    a_req = 2'b00;
    step();
    chk("t1_done", a_done, 2'b01);
    chk("t1_err", a_err, 0);
    chk("t1_re_off", a_re, 0);
    chk("t1_rdata", a_rdata, 16'hBEEF);
    step();
    chk("t1_done_pulse", a_done, 0);

    // Write on port 1 with two wait states; operands changed after grant
    a_req = 2'b10; a_we = 2'b10; a_wdata = {16'h1234, 16'h0000}; a_nw = 1'b1;
    step();
    chk("t2_we", a_we_o, 1);
    chk("t2_re", a_re, 0);
    chk("t2_gnt", a_gnt, 2'b10);
    chk("t2_addr", a_addr_o, 16'h0200);
    chk("t2_be", a_be_o, 2'b01);
    chk("t2_data", a_data, 16'h1234);
    a_req = 2'b00; a_wdata = 32'hFFFF_FFFF; a_addr = 32'hFFFF_FFFF;
    step();
    chk("t2_we_w1", a_we_o, 1);
    chk("t2_data_w1", a_data, 16'h1234);
    step();
    chk("t2_we_w2", a_we_o, 1);
    chk("t2_addr_held", a_addr_o, 16'h0200);
    chk("t2_done_early", a_done, 0);
    a_nw = 1'b0;
    step();
    chk("t2_done", a_done, 2'b10);
    chk("t2_we_off", a_we_o, 0);
    chk("t2_rdata_kept", a_rdata, 16'hBEEF);
    a_we = 2'b00;
    step();

    // Simultaneous requests, fixed priority; port 1 granted in port 0's done cycle
    a_req = 2'b11; a_addr = {16'h0400, 16'h0300}; a_slv = 16'h5555;
    step();
    chk("t3_gnt0", a_gnt, 2'b01);
    chk("t3_addr0", a_addr_o, 16'h0300);
    step();
    chk("t3_done0", a_done, 2'b01);
    chk("t3_rdata0", a_rdata, 16'h5555);
    a_req = 2'b10; a_slv = 16'h6666;
    step();
    chk("t3_gnt1", a_gnt, 2'b10);
    chk("t3_addr1", a_addr_o, 16'h0400);
    chk("t3_done_gap", a_done, 0);
    a_req = 2'b00;
    step();
    chk("t3_done1", a_done, 2'b10);
    chk("t3_rdata1", a_rdata, 16'h6666);
    step();

    // Timeout: needWait stuck high, abort after four wait edges
    a_req = 2'b01; a_addr = {16'h0600, 16'h0500}; a_slv = 16'h7777; a_nw = 1'b1;
    step();
    chk("t5_re", a_re, 1);
    a_req = 2'b00;
    step(); step(); step();
    chk("t5_re_w3", a_re, 1);
    chk("t5_done_early", a_done, 0);
    step();
    chk("t5_done", a_done, 2'b01);
    chk("t5_err", a_err, 2'b01);
    chk("t5_re_off", a_re, 0);
    chk("t5_rdata_kept", a_rdata, 16'h6666);
    step();
    chk("t5_err_pulse", a_err, 0);
    a_nw = 1'b0; a_req = 2'b10; a_slv = 16'h8888;
    step();
    chk("t5_next_gnt", a_gnt, 2'b10);
    a_req = 2'b00;
    step();
    chk("t5_next_done", a_done, 2'b10);
    chk("t5_next_err", a_err, 0);
    chk("t5_next_rdata", a_rdata, 16'h8888);
    step();

    // Reset in the middle of an access
    a_req = 2'b01; a_nw = 1'b1;
    step();
    chk("t6_re_pre", a_re, 1);
    a_req = 2'b00; rst = 1'b1;
    step();
    chk("t6_re", a_re, 0);
    chk("t6_gnt", a_gnt, 0);
    chk("t6_we", a_we_o, 0);
    chk("t6_done", a_done, 0);
    rst = 1'b0; a_nw = 1'b0;
    step();
    chk("t6_no_done", a_done, 0);
    chk("t6_idle_re", a_re, 0);

    // Round-robin: 0,1,0,1 with ports 0/1, then port 2 joins and is served next
    b_req = 3'b011;
    for (int k = 0; k < 7; k++) begin
      if (k == 4) b_req = 3'b111;
      b_slv = 16'hA000 + 16'(k);
      step();
      chk($sformatf("rr_gnt%0d", k), b_gnt, 64'(3'b001 << exp_g[k]));
      chk($sformatf("rr_addr%0d", k), b_addr_o, 64'(16'h1000 + exp_g[k]));
      step();
      chk($sformatf("rr_done%0d", k), b_done, 64'(3'b001 << exp_g[k]));
      chk($sformatf("rr_rdata%0d", k), b_rdata, 64'(16'hA000 + k));
    end
    b_req = 3'b000;
    step();
    chk("rr_idle", b_gnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
